// File: rtl/ray_dispatcher_pkg.sv
// Shared types for the primary-ray dispatcher.
// Fixed-point vectors, camera state and core input bundle.
package ray_dispatcher_pkg;

  localparam int SCREEN_COORD_WIDTH = 16;

  typedef logic [SCREEN_COORD_WIDTH-1:0] coord_t;
  typedef logic signed [31:0] fixed_t;

  typedef struct packed {
    fixed_t x;
    fixed_t y;
    fixed_t z;
  } fixed3_t;

  typedef struct packed {
    fixed3_t eye;
    fixed3_t dir_base;
    fixed3_t pixel_dx;
    fixed3_t pixel_dy;
  } render_state_t;

  typedef struct packed {
    coord_t     x;
    coord_t     y;
    fixed3_t    origin;
    fixed3_t    dir;
    logic [3:0] bounce_level;
  } surface_input_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } dispatch_state_t;

  // Plain two's complement add; overflow wraps.
  function automatic fixed_t fixed_add(fixed_t a, fixed_t b);
    return a + b;
  endfunction

  function automatic fixed3_t fixed3_add(fixed3_t a, fixed3_t b);
    fixed3_t r;
    r.x = fixed_add(a.x, b.x);
    r.y = fixed_add(a.y, b.y);
    r.z = fixed_add(a.z, b.z);
    return r;
  endfunction

endpackage

// File: rtl/ray_dispatcher_raster_stepper.sv
// Raster walker: pixel coordinates and incremental ray directions.
// Holds on the final pixel so the frame end is stable.
module ray_dispatcher_raster_stepper
  import ray_dispatcher_pkg::*;
#(
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480
) (
  input  logic    clk,
  input  logic    resetn,
  input  logic    load,
  input  logic    step,
  input  fixed3_t dir_base,
  input  fixed3_t pixel_dx,
  input  fixed3_t pixel_dy,
  output coord_t  x,
  output coord_t  y,
  output fixed3_t cur_dir,
  output logic    last_pixel
);

  localparam coord_t X_MAX = coord_t'(SCREEN_WIDTH - 1);
  localparam coord_t Y_MAX = coord_t'(SCREEN_HEIGHT - 1);

  fixed3_t row_dir;

  assign last_pixel = (x == X_MAX) && (y == Y_MAX);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      x       <= '0;
      y       <= '0;
      cur_dir <= '0;
      row_dir <= '0;
    end else if (load) begin
      x       <= '0;
      y       <= '0;
      cur_dir <= dir_base;
      row_dir <= dir_base;
    end else if (step && !last_pixel) begin
      if (x != X_MAX) begin
        x       <= x + coord_t'(1);
        cur_dir <= fixed3_add(cur_dir, pixel_dx);
      end else begin
        x       <= '0;
        y       <= y + coord_t'(1);
        row_dir <= fixed3_add(row_dir, pixel_dy);
        cur_dir <= fixed3_add(row_dir, pixel_dy);
      end
    end
  end

endmodule

// File: rtl/ray_dispatcher.sv
// Primary-ray front end: issues one ray per pixel into the core
// under back-pressure and tracks retired pixels to frame completion.
module ray_dispatcher
  import ray_dispatcher_pkg::*;
#(
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           start,
  input  render_state_t  rs,
  input  logic           fifo_full,
  output logic           add_input,
  output surface_input_t input_data,
  input  logic           pixel_retired,
  output logic           busy,
  output logic           frame_done,
  output logic [31:0]    issued_count,
  output logic [31:0]    retired_count
);

  localparam logic [31:0] TOTAL = 32'(SCREEN_WIDTH * SCREEN_HEIGHT);

  dispatch_state_t state, next_state;

  fixed3_t     eye, dx, dy, cur_dir;
  coord_t      x, y;
  logic        last_pixel, load, counting;
  logic [31:0] next_retired;

  assign counting     = pixel_retired && (state == ISSUE || state == DRAIN);
  assign next_retired = retired_count + 32'(counting);

  always_comb begin
    next_state = state;
    add_input  = 1'b0;
    load       = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          next_state = ISSUE;
          load       = 1'b1;
        end
      end
      ISSUE: begin
        add_input = !fifo_full;
        if (!fifo_full && last_pixel) next_state = DRAIN;
      end
      DRAIN: begin
        if (next_retired == TOTAL) next_state = DONE;
      end
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= next_state;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      busy          <= 1'b0;
      frame_done    <= 1'b0;
      issued_count  <= '0;
      retired_count <= '0;
      eye           <= '0;
      dx            <= '0;
      dy            <= '0;
    end else begin
      busy       <= (next_state != IDLE);
      frame_done <= (next_state == DONE);
      if (load) begin
        eye           <= rs.eye;
        dx            <= rs.pixel_dx;
        dy            <= rs.pixel_dy;
        issued_count  <= '0;
        retired_count <= '0;
      end else begin
        if (add_input) issued_count <= issued_count + 32'd1;
        retired_count <= next_retired;
      end
    end
  end

  ray_dispatcher_raster_stepper #(
    .SCREEN_WIDTH (SCREEN_WIDTH),
    .SCREEN_HEIGHT(SCREEN_HEIGHT)
  ) u_stepper (
    .clk       (clk),
    .resetn    (resetn),
    .load      (load),
    .step      (add_input),
    .dir_base  (rs.dir_base),
    .pixel_dx  (dx),
    .pixel_dy  (dy),
    .x         (x),
    .y         (y),
    .cur_dir   (cur_dir),
    .last_pixel(last_pixel)
  );

  assign input_data = '{
    x:            x,
    y:            y,
    origin:       eye,
    dir:          cur_dir,
    bounce_level: 4'd0
  };

endmodule

// File: doc/ray_dispatcher.md
# ray_dispatcher

Primary-ray front end feeding the ray core.
- On a `start` pulse, walks the screen in raster order (x fastest) and builds one primary-ray `SurfaceInputData` per pixel, stepping ray directions incrementally with adds only, no multipliers.
- Pushes each ray into the core's surface input FIFO under `fifo_full` back-pressure.
- Counts pixels the core retires and reports frame completion.

## Interface
Parameters:
- `SCREEN_WIDTH`, 640, pixels per row (≥2).
- `SCREEN_HEIGHT`, 480, rows per frame (≥1).

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `resetn`  in  1  synchronous, active-low reset.
- `start`  in  1  one-cycle frame start request.
- `rs`  in  RenderState  camera: `eye` (Fixed3), `dir_base` (Fixed3, ray direction of pixel 0,0), `pixel_dx`, `pixel_dy` (Fixed3 per-pixel steps).
- `fifo_full`  in  1  ray core surface input FIFO full.
- `add_input`  out  1  push strobe to the ray core.
- `input_data`  out  SurfaceInputData  ray being pushed:
  - `x`, `y`
  - `origin` = latched eye
  - `dir`
  - `bounce_level` = 0
- `pixel_retired`  in  1  ray core `valid` (one pixel written to frame buffer).
- `busy`  out  1  high from frame start until `frame_done`.
- `frame_done`  out  1  one-cycle completion pulse.
- `issued_count`  out  32  rays pushed this frame.
- `retired_count`  out  32  pixels retired this frame.

## Operation
- **Reset values:** state IDLE; `add_input`, `busy`, `frame_done` = 0; `issued_count`, `retired_count`, `x`, `y` = 0; direction registers = 0.
- **IDLE:**
  - `start`=1 → ISSUE.
  - Snapshot `rs` eye/dx/dy into local registers; `rs` changes mid-frame are ignored.
  - Set `cur_dir` = `row_dir` = `rs.dir_base`, x = y = 0, both counters = 0.
- **ISSUE:**
  - `add_input` = (state==ISSUE) && !`fifo_full`. This is the only combinational path.
  - `input_data` is registered and reflects the current pixel.
  - On each push: `issued_count`+1.
  - If x < W-1: x+1, `cur_dir` += `pixel_dx`.
  - Else: x = 0, y+1, `row_dir` += `pixel_dy`, `cur_dir` = `row_dir` + `pixel_dy`.
  - The push of pixel (W-1, H-1) → DRAIN; x and y hold.
- **DRAIN:** `add_input` = 0; wait until `retired_count` == W·H.
- **DONE:** one cycle, `frame_done` = 1, then → IDLE. `busy` = 1 in ISSUE, DRAIN and DONE.
- **Arithmetic:** Fixed3 component adds use the shared Fixed add and wrap in two's complement; there is no saturation.
- **Boundary conditions:**
  - **Retire counting:** `pixel_retired` is counted in ISSUE and DRAIN only and ignored in IDLE and DONE. It is counted in the same cycle as a push, independently of it.
  - **Stall:** `fifo_full` held high stalls indefinitely with all state frozen.
  - **Start while busy:** `start` while busy is ignored. `start` in the DONE cycle is also ignored.
  - **Reset mid-frame:** IDLE next cycle with all outputs at reset values. Rays already in the core are not flushed; their later retires are ignored.
  - **Over-retire:** `retired_count` exceeding W·H is impossible by construction. Compare with == only.

## Timing
- `start` at cycle t → ISSUE at t+1 → first `add_input` possible at t+1.
- Throughput is 1 ray/cycle. The last push is at t+W·H with no stalls; each `fifo_full` cycle adds one cycle.
- `fifo_full` → `add_input` has zero-cycle latency, so the core samples both in the same cycle.
- The retire that makes `retired_count` = W·H at cycle r gives DONE (`frame_done` = 1) at r+1 and IDLE at r+2.

## Structure
- **Shared package** (alongside RenderState / SurfaceInputData):
  - RenderState fields `dir_base`, `pixel_dx`, `pixel_dy`.
  - SurfaceInputData fields `x`, `y`, `bounce_level`.
  - State enum `DispatchState` {IDLE, ISSUE, DRAIN, DONE}.
  - Coordinate width `SCREEN_COORD_WIDTH` = 16.
- **Sub-module `_RasterStepper`:** x/y counters, the `row_dir`/`cur_dir` accumulators, and `last_pixel` detect, advanced by a `step` input. The FSM and counters stay in `ray_dispatcher`.

## Test plan
- **No stall:** W=4, H=2, `dir_base`=(0,0,1), dx=(1,0,0), dy=(0,1,0), `fifo_full`=0, `start` at t=0 → 8 pushes on t=1..8. Pixel (3,1) has dir=(3,1,1) and pixel (0,1) has dir=(0,1,1). DRAIN from t=9.
- **Back-pressure:** same frame with `fifo_full`=1 on cycles 3–5 → no push on 3–5, pixel order unchanged, last push at t=11.
- **Retire/done:** 8 `pixel_retired` pulses, one in the same cycle as a push → `retired_count`=8, `frame_done` one cycle later, `busy` low the cycle after.
- **Ignored inputs:** `start` mid-ISSUE and `rs.pixel_dx` changed mid-frame → no restart, and directions still use the latched dx.
- **Reset mid-frame:** `resetn`=0 after 3 pushes → next cycle IDLE, counters 0, `add_input`=0. Later `pixel_retired` pulses leave `retired_count`=0.
- **Wrap:** `dir_base` x component = 0x7FFFFFFF, dx = +1 → pixel 1 has x = 0x80000000.
